// File: rtl/dvbc_conv_interleaver.sv
// ============================================================================
// dvbc_conv_interleaver - Forney convolutional byte interleaver, valid/ready
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dvbc_conv_interleaver #(
  parameter int DATA_W     = 8,
  parameter int BRANCHES   = 12,
  parameter int DEPTH_UNIT = 17,
  parameter int SIMULATION = 0,
  parameter int DEBUG      = 0,
  localparam int BR_W      = (BRANCHES > 1) ? $clog2(BRANCHES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sync_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sync_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sync_err_o,
  output logic [BR_W-1:0]   branch_o
);

  localparam int POS_SPAN  = (BRANCHES - 1) * DEPTH_UNIT;
  localparam int POS_W     = (POS_SPAN > 1) ? $clog2(POS_SPAN) : 1;
  localparam int RAM_WORDS = (DEPTH_UNIT * BRANCHES * (BRANCHES - 1)) / 2;
  localparam int ADDR_W    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [BR_W-1:0]     branch_q, branch_d, eff_b;
  logic [POS_W-1:0]    pos_q [BRANCHES];
  logic [BRANCHES-1:0] filled_q;
  logic [DATA_W-1:0]   data_q;
  logic                sync_q, valid_q, err_q;
  logic [DATA_W-1:0]   ram [RAM_WORDS];

  logic [ADDR_W-1:0]   base_tab [BRANCHES];
  logic [POS_W-1:0]    last_tab [BRANCHES];
  logic [ADDR_W-1:0]   addr;
  logic                accept, realign, wrap, to_ring;

  // Ring base and last position of every branch are elaboration-time constants
  for (genvar j = 0; j < BRANCHES; j++) begin : g_tab
    assign base_tab[j] = ADDR_W'((DEPTH_UNIT * j * (j - 1)) / 2);
    assign last_tab[j] = POS_W'((j == 0) ? 0 : (j * DEPTH_UNIT - 1));
  end

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  always_comb begin
    realign  = sync_i && (branch_q != '0);
    eff_b    = sync_i ? '0 : branch_q;
    to_ring  = (eff_b != '0);
    addr     = base_tab[eff_b] + ADDR_W'(pos_q[eff_b]);
    wrap     = (pos_q[eff_b] == last_tab[eff_b]);
    branch_d = (eff_b == BR_W'(BRANCHES - 1)) ? '0 : eff_b + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      branch_q <= '0;
      filled_q <= '0;
      data_q   <= '0;
      sync_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < BRANCHES; i++) pos_q[i] <= '0;
    end else begin
      err_q <= accept && realign;
      if (accept) begin
        valid_q  <= 1'b1;
        branch_q <= branch_d;
        if (!to_ring) begin
          data_q <= data_i;
          sync_q <= sync_i;
        end else begin
          // Cells never written since reset read as zero, hiding stale RAM
          data_q        <= filled_q[eff_b] ? ram[addr] : '0;
          sync_q        <= 1'b0;
          pos_q[eff_b]  <= wrap ? '0 : pos_q[eff_b] + 1'b1;
          if (wrap) filled_q[eff_b] <= 1'b1;
        end
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && to_ring) ram[addr] <= data_i;
  end

  assign data_o     = data_q;
  assign sync_o     = sync_q;
  assign valid_o    = valid_q;
  assign sync_err_o = err_q;

  if (DEBUG != 0) begin : g_dbg
    assign branch_o = branch_q;
  end else begin : g_nodbg
    assign branch_o = '0;
  end

  if (SIMULATION != 0) begin : g_sim
    always_ff @(posedge clk_i) begin
      if (rst_n_i) assert (!(sync_i && !valid_i)) else $error("sync_i asserted without valid_i");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dvbc_conv_interleaver.sv
// ============================================================================
// tb_dvbc_conv_interleaver - scoreboard bench for the convolutional interleaver
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dvbc_conv_interleaver;

  localparam int NB = 12;
  localparam int NM = 17;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i, data_o;
  logic       sync_i, valid_i, ready_i, ready_o, sync_o, valid_o, sync_err_o;
  logic [3:0] branch_o;

  logic [7:0] s_data_i, s_data_o;
  logic       s_sync_i, s_valid_i, s_ready_i, s_ready_o, s_sync_o, s_valid_o, s_err_o;
  logic [1:0] s_branch_o;

  always #5 clk = ~clk;

  dvbc_conv_interleaver #(.DATA_W(8), .BRANCHES(NB), .DEPTH_UNIT(NM),
                          .SIMULATION(1), .DEBUG(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .sync_i(sync_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .sync_o(sync_o),
    .valid_o(valid_o), .ready_i(ready_i), .sync_err_o(sync_err_o),
    .branch_o(branch_o));

  dvbc_conv_interleaver #(.DATA_W(8), .BRANCHES(3), .DEPTH_UNIT(2),
                          .SIMULATION(1), .DEBUG(0)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(s_data_i), .sync_i(s_sync_i),
    .valid_i(s_valid_i), .ready_o(s_ready_o), .data_o(s_data_o), .sync_o(s_sync_o),
    .valid_o(s_valid_o), .ready_i(s_ready_i), .sync_err_o(s_err_o),
    .branch_o(s_branch_o));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: each branch b is a pure delay line of b*M of its own bytes
  logic [7:0] m_hist [NB][256];
  int         m_cnt [NB];
  int         m_ptr;
  logic [8:0] sb[$];
  logic [7:0] in_log[$];
  logic [7:0] out_log[$];
  logic       exp_err, hold_prev, hold_sync, last_acc;
  logic [7:0] hold_data;
  int         n_sync;

  task automatic model_clear();
    for (int b = 0; b < NB; b++) m_cnt[b] = 0;
    m_ptr = 0; sb.delete(); in_log.delete(); out_log.delete();
    exp_err = 1'b0; hold_prev = 1'b0; n_sync = 0;
  endtask

  task automatic model_push(input logic [7:0] d, input logic s);
    int b;
    logic [7:0] e;
    b = s ? 0 : m_ptr;
    m_hist[b][m_cnt[b] % 256] = d;
    e = (m_cnt[b] >= b * NM) ? m_hist[b][(m_cnt[b] - b * NM) % 256] : 8'h00;
    m_cnt[b]++;
    sb.push_back({(b == 0) ? s : 1'b0, e});
    m_ptr = (b == NB - 1) ? 0 : b + 1;
  endtask

  // One clock: drive at negedge, then check what the DUT shows in this cycle
  task automatic cycle(input logic v, input logic [7:0] d, input logic s, input logic r);
    logic [8:0] e;
    @(negedge clk);
    valid_i = v; data_i = d; sync_i = s & v; ready_i = r;
    #1;
    check_eq("sync_err", 32'(sync_err_o), 32'(exp_err));
    check_eq("branch", 32'(branch_o), 32'(m_ptr));
    if (hold_prev) begin
      check_eq("hold_valid", 32'(valid_o), 32'd1);
      check_eq("hold_data", 32'(data_o), 32'(hold_data));
      check_eq("hold_sync", 32'(sync_o), 32'(hold_sync));
    end
    if (valid_o && ready_i) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("out_data", 32'(data_o), 32'(e[7:0]));
        check_eq("out_sync", 32'(sync_o), 32'(e[8]));
      end
      out_log.push_back(data_o);
      if (sync_o) n_sync++;
    end
    last_acc = v && ready_o;
    exp_err  = 1'b0;
    if (last_acc) begin
      exp_err = s && (m_ptr != 0);
      in_log.push_back(d);
      model_push(d, s);
    end
    hold_prev = valid_o && !ready_i;
    hold_data = data_o;
    hold_sync = sync_o;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input int low_pct);
    for (int t = 0; t < 100; t++) begin
      cycle(1'b1, d, s, $urandom_range(0, 99) >= low_pct);
      if (last_acc) return;
    end
    check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && (sb.size() != 0 || valid_o); t++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; valid_i = 1'b1; sync_i = 1'b0; ready_i = 1'b1; data_i = 8'hAA;
    repeat (n) @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    check_eq("rst_err", 32'(sync_err_o), 32'd0);
    check_eq("rst_branch", 32'(branch_o), 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    rst_n = 1'b1;
    model_clear();
  endtask

  logic [7:0] s_log[$];
  logic [7:0] rb;

  initial begin
    rst_n = 1'b0; data_i = '0; sync_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    s_data_i = '0; s_sync_i = 1'b0; s_valid_i = 1'b0; s_ready_i = 1'b1;
    model_clear();

    do_reset(3);

    // Small configuration: I=3, M=2, bytes 1,2,3,...
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      s_valid_i = (k < 20);
      s_data_i  = 8'(k + 1);
      #1;
      if (s_valid_o) s_log.push_back(s_data_o);
    end
    s_valid_i = 1'b0;
    check_eq("small_count", 32'(s_log.size()), 32'd20);
    if (s_log.size() == 20) begin
      check_eq("small_idx0", 32'(s_log[0]), 32'd1);
      check_eq("small_idx1", 32'(s_log[1]), 32'd0);
      check_eq("small_idx4", 32'(s_log[4]), 32'd0);
      check_eq("small_idx7", 32'(s_log[7]), 32'd2);
      check_eq("small_idx14", 32'(s_log[14]), 32'd3);
    end

    // Four aligned 204-byte packets
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 204; i++)
        send((i == 0) ? 8'h47 : 8'($urandom), i == 0, 0);
    drain();
    check_eq("pkt_count", 32'(out_log.size()), 32'd816);
    check_eq("pkt_nsync", 32'(n_sync), 32'd4);
    if (out_log.size() == 816) begin
      for (int p = 0; p < 4; p++) check_eq("pkt_sync_byte", 32'(out_log[204 * p]), 32'h47);
      check_eq("pkt_branch1_delay", 32'(out_log[205]), 32'(in_log[1]));
    end

    // Sync byte arriving on branch 4
    do_reset(2);
    for (int i = 0; i < 4; i++) send(8'(8'h11 + i), 1'b0, 0);
    send(8'h47, 1'b1, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("mis_err", 32'(sync_err_o), 32'd1);
    check_eq("mis_branch", 32'(branch_o), 32'd1);
    check_eq("mis_sync_o", 32'(sync_o && valid_o), 32'd1);
    check_eq("mis_data", 32'(data_o), 32'h47);
    for (int i = 0; i < 30; i++) send(8'($urandom), 1'b0, 0);
    drain();

    // Random backpressure and input gaps over 5000 bytes
    do_reset(2);
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 9) < 2) cycle(1'b0, 8'h00, 1'b0, $urandom_range(0, 99) >= 30);
      send(((i % 204) == 0) ? 8'h47 : 8'($urandom), (i % 204) == 0, 30);
    end
    drain();
    check_eq("bp_count", 32'(out_log.size()), 32'd5000);

    // Mid-stream reset, then replay: stale RAM must stay hidden
    do_reset(2);
    for (int i = 0; i < 500; i++) send(8'((i % 255) + 1), 1'b0, 20);
    do_reset(1);
    for (int i = 0; i < 500; i++) begin
      rb = 8'((i % 255) + 1);
      send(rb, 1'b0, 0);
    end
    drain();
    check_eq("replay_count", 32'(out_log.size()), 32'd500);
    if (out_log.size() == 500) begin
      check_eq("replay_unfilled", 32'(out_log[1]), 32'd0);
      check_eq("replay_branch1", 32'(out_log[205]), 32'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
